// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam int PC_WIDTH = 5;

  typedef logic [PC_WIDTH-1:0] pc_type;
  typedef logic [31:0]         instruction_type;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_type;

  localparam instruction_type NOP_INSTRUCTION = 32'h0000_0013;

  typedef struct packed {
    pc_type          pc;
    instruction_type instruction;
  } if_id_type;

  localparam if_id_type IF_ID_RESET = '{pc: 5'd0, instruction: NOP_INSTRUCTION};

  // Word-index increment; wraps 31 -> 0 by width.
  function automatic pc_type pc_inc(input pc_type pc);
    return pc + 5'd1;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and memory.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic            req;
  pc_type          addr;
  logic            ack;
  instruction_type rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry IF/ID holding register that catches a fetch returning while decode is stalled.
module fetch_skid_buffer
  import fetch_stage_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      load,
  input  logic      unload,
  input  logic      clear,
  input  if_id_type din,
  output if_id_type dout
);

  if_id_type data_r;
  logic      full_r;

  // Entry storage: clear beats load beats unload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_r <= IF_ID_RESET;
      full_r <= 1'b0;
    end else if (clear) begin
      data_r <= IF_ID_RESET;
      full_r <= 1'b0;
    end else if (load) begin
      data_r <= din;
      full_r <= 1'b1;
    end else if (unload) begin
      full_r <= 1'b0;
    end else begin
      full_r <= full_r;
    end
  end

  assign dout = full_r ? data_r : IF_ID_RESET;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, fetches over a req/ack bus, skids decode stalls, drains on redirect.
// Optional macro FETCH_PERF_CNT_EN adds a saturating fetch_stall_cycles counter output.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter pc_type RESET_PC = 5'd0
) (
  input  logic          clk,
  input  logic          reset_n,
  fetch_stage_if.master imem,
  input  logic          stall,
  input  logic          redirect,
  input  pc_type        redirect_pc,
  output if_id_type     if_id,
  output logic          if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]   fetch_stall_cycles
`endif
);

  fetch_state_type state_r, state_s;
  pc_type          pc_r, pc_s;
  pc_type          target_r, target_s;
  if_id_type       if_id_r, if_id_s;
  logic            if_id_valid_r, if_id_valid_s;
  logic            req_r;
  logic            acked_s;
  logic            skid_load_s, skid_unload_s, skid_clear_s;
  if_id_type       fetched_s, skid_q_s;

  assign acked_s   = req_r & imem.ack;
  assign fetched_s = '{pc: pc_r, instruction: imem.rdata};

  fetch_skid_buffer u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (skid_load_s),
    .unload  (skid_unload_s),
    .clear   (skid_clear_s),
    .din     (fetched_s),
    .dout    (skid_q_s)
  );

  // State register plus all datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= FETCH;
      pc_r          <= RESET_PC;
      target_r      <= 5'd0;
      if_id_r       <= IF_ID_RESET;
      if_id_valid_r <= 1'b0;
      req_r         <= 1'b0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      target_r      <= target_s;
      if_id_r       <= if_id_s;
      if_id_valid_r <= if_id_valid_s;
      req_r         <= (state_s != HOLD);
    end
  end

  // Next-state: an unacked request under redirect must drain before refetching.
  always_comb begin
    state_s = state_r;
    case (state_r)
      FETCH: begin
        if (redirect) begin
          state_s = (req_r && !imem.ack) ? DRAIN : FETCH;
        end else if (acked_s && stall && if_id_valid_r) begin
          state_s = HOLD;
        end else begin
          state_s = FETCH;
        end
      end
      HOLD: begin
        if (redirect || !stall) begin
          state_s = FETCH;
        end else begin
          state_s = HOLD;
        end
      end
      DRAIN: begin
        if (acked_s) begin
          state_s = FETCH;
        end else begin
          state_s = DRAIN;
        end
      end
      default: state_s = FETCH;
    endcase
  end

  // Datapath controls per state; redirect flushes IF/ID and the skid.
  always_comb begin
    pc_s          = pc_r;
    target_s      = target_r;
    if_id_s       = if_id_r;
    if_id_valid_s = if_id_valid_r;
    skid_load_s   = 1'b0;
    skid_unload_s = 1'b0;
    skid_clear_s  = 1'b0;
    case (state_r)
      FETCH: begin
        if (redirect) begin
          if_id_valid_s        = 1'b0;
          if_id_s.instruction  = NOP_INSTRUCTION;
          skid_clear_s         = 1'b1;
          if (req_r && !imem.ack) begin
            target_s = redirect_pc;
          end else begin
            pc_s = redirect_pc;
          end
        end else if (acked_s) begin
          pc_s = pc_inc(pc_r);
          if (!stall || !if_id_valid_r) begin
            if_id_s       = fetched_s;
            if_id_valid_s = 1'b1;
          end else begin
            skid_load_s = 1'b1;
          end
        end else if (!stall) begin
          if_id_valid_s       = 1'b0;
          if_id_s.instruction = NOP_INSTRUCTION;
        end else begin
          if_id_s = if_id_r;
        end
      end
      HOLD: begin
        if (redirect) begin
          if_id_valid_s       = 1'b0;
          if_id_s.instruction = NOP_INSTRUCTION;
          skid_clear_s        = 1'b1;
          pc_s                = redirect_pc;
        end else if (!stall) begin
          if_id_s       = skid_q_s;
          if_id_valid_s = 1'b1;
          skid_unload_s = 1'b1;
        end else begin
          if_id_s = if_id_r;
        end
      end
      DRAIN: begin
        if_id_valid_s       = 1'b0;
        if_id_s.instruction = NOP_INSTRUCTION;
        if (redirect) begin
          target_s     = redirect_pc;
          skid_clear_s = 1'b1;
        end else begin
          target_s = target_r;
        end
        if (acked_s) begin
          pc_s = target_s;
        end else begin
          pc_s = pc_r;
        end
      end
      default: begin
        pc_s = pc_r;
      end
    endcase
  end

  assign imem.req    = req_r;
  assign imem.addr   = pc_r;
  assign if_id       = if_id_r;
  assign if_id_valid = if_id_valid_r;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_r;

  // Counts waiting-on-memory and skid-hold cycles, saturating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_r <= 16'd0;
    end else if (((req_r && !imem.ack) || (state_r == HOLD)) && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign fetch_stall_cycles = stall_cnt_r;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage; FETCH_PERF_CNT_EN also checks the stall counter.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic      clk = 1'b0;
  logic      reset_n;
  logic      stall;
  logic      redirect;
  pc_type    redirect_pc;
  if_id_type if_id;
  logic      if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_stall_cycles;
`endif

  int vectors     = 0;
  int miscompares = 0;

  fetch_stage_if imem_bus ();

  fetch_stage #(.RESET_PC(5'd0)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem        (imem_bus),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_id       (if_id),
    .if_id_valid (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_stall_cycles (fetch_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input pc_type a);
    return {16'hC0DE, 11'd0, a};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; return at the following negedge with rdata matching the new address.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    imem_bus.rdata = enc(imem_bus.addr);
  endtask

  initial begin
    reset_n        = 1'b0;
    stall          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 5'd0;
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = enc(5'd0);
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_req",   32'(imem_bus.req), 32'd0);
    check_eq("rst_valid", 32'(if_id_valid), 32'd0);
    check_eq("rst_pc",    32'(if_id.pc), 32'd0);
    check_eq("rst_instr", if_id.instruction, 32'h0000_0013);
    check_eq("rst_addr",  32'(imem_bus.addr), 32'd0);

    // Streaming with ack tied high, including the 31 -> 0 wrap.
    reset_n = 1'b1;
    cyc();
    check_eq("idle_req",   32'(imem_bus.req), 32'd1);
    check_eq("idle_valid", 32'(if_id_valid), 32'd0);
    for (int k = 0; k < 34; k++) begin
      cyc();
      check_eq("stream_pc",    32'(if_id.pc), 32'(k % 32));
      check_eq("stream_valid", 32'(if_id_valid), 32'd1);
      check_eq("stream_instr", if_id.instruction, enc(5'(k % 32)));
    end

    // Redirect coincident with an ack.
    redirect = 1'b1; redirect_pc = 5'd20;
    cyc();
    check_eq("redir_valid", 32'(if_id_valid), 32'd0);
    check_eq("redir_instr", if_id.instruction, 32'h0000_0013);
    check_eq("redir_addr",  32'(imem_bus.addr), 32'd20);
    redirect = 1'b0;
    cyc();
    check_eq("redir_pc20", 32'(if_id.pc), 32'd20);

    // Stall with ack high: pc 2 frozen, pc 3 in the skid.
    redirect = 1'b1; redirect_pc = 5'd0;
    cyc();
    redirect = 1'b0;
    cyc(); cyc(); cyc();
    check_eq("pre_stall_pc",   32'(if_id.pc), 32'd2);
    check_eq("pre_stall_addr", 32'(imem_bus.addr), 32'd3);
    stall = 1'b1;
    for (int s = 0; s < 4; s++) begin
      cyc();
      check_eq("stall_pc",    32'(if_id.pc), 32'd2);
      check_eq("stall_valid", 32'(if_id_valid), 32'd1);
      check_eq("stall_req",   32'(imem_bus.req), 32'd0);
    end
    check_eq("stall_addr", 32'(imem_bus.addr), 32'd4);
    stall = 1'b0;
    cyc();
    check_eq("unskid_pc",    32'(if_id.pc), 32'd3);
    check_eq("unskid_instr", if_id.instruction, enc(5'd3));
    check_eq("unskid_req",   32'(imem_bus.req), 32'd1);
    cyc();
    check_eq("after_pc",    32'(if_id.pc), 32'd4);
    check_eq("after_instr", if_id.instruction, enc(5'd4));

    // Slow memory: ack on the third cycle of the request.
    imem_bus.ack = 1'b0;
    for (int w = 0; w < 2; w++) begin
      cyc();
      check_eq("wait_addr",  32'(imem_bus.addr), 32'd5);
      check_eq("wait_valid", 32'(if_id_valid), 32'd0);
    end
    imem_bus.ack = 1'b1;
    cyc();
    check_eq("slow_pc",   32'(if_id.pc), 32'd5);
    check_eq("slow_addr", 32'(imem_bus.addr), 32'd6);
    imem_bus.ack = 1'b0;
    cyc();
    check_eq("slow_bubble", 32'(if_id_valid), 32'd0);

    // Redirect against an outstanding request must drain it first.
    redirect = 1'b1; redirect_pc = 5'd5; imem_bus.ack = 1'b1;
    cyc();
    check_eq("drain_setup_addr", 32'(imem_bus.addr), 32'd5);
    redirect = 1'b0; imem_bus.ack = 1'b0;
    cyc();
    redirect = 1'b1; redirect_pc = 5'd9;
    cyc();
    redirect = 1'b0;
    check_eq("drain_addr",  32'(imem_bus.addr), 32'd5);
    check_eq("drain_req",   32'(imem_bus.req), 32'd1);
    check_eq("drain_valid", 32'(if_id_valid), 32'd0);
    cyc();
    check_eq("drain_hold_addr", 32'(imem_bus.addr), 32'd5);
    imem_bus.ack = 1'b1;
    cyc();
    check_eq("drain_target", 32'(imem_bus.addr), 32'd9);
    check_eq("drain_discard", 32'(if_id_valid), 32'd0);
    cyc();
    check_eq("drain_pc9",    32'(if_id.pc), 32'd9);
    check_eq("drain_instr9", if_id.instruction, enc(5'd9));

    // Mid-run reset, then 5 unacked request cycles and 2 skid-hold cycles.
    reset_n = 1'b0; imem_bus.ack = 1'b0;
    #1;
    check_eq("rst2_req",   32'(imem_bus.req), 32'd0);
    check_eq("rst2_valid", 32'(if_id_valid), 32'd0);
    check_eq("rst2_instr", if_id.instruction, 32'h0000_0013);
`ifdef FETCH_PERF_CNT_EN
    check_eq("rst2_cnt", 32'(fetch_stall_cycles), 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    imem_bus.rdata = enc(imem_bus.addr);
    cyc();
    for (int w = 0; w < 5; w++) cyc();
    check_eq("perf_addr", 32'(imem_bus.addr), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check_eq("perf_cnt5", 32'(fetch_stall_cycles), 32'd5);
`endif
    imem_bus.ack = 1'b1;
    cyc();
    check_eq("perf_pc0", 32'(if_id.pc), 32'd0);
    stall = 1'b1;
    cyc();
    check_eq("perf_hold_req", 32'(imem_bus.req), 32'd0);
    cyc();
    stall = 1'b0;
    cyc();
    check_eq("perf_pc1", 32'(if_id.pc), 32'd1);
`ifdef FETCH_PERF_CNT_EN
    check_eq("perf_cnt7", 32'(fetch_stall_cycles), 32'd7);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
